// File: rtl/led_7seg_if.sv
// led_7seg_if: pin bundle between the switch/display board pins and led_7seg.
//   I1, I2 : switch inputs (asynchronous to the display clock)
//   LED    : segment drive, active-low, [0]=a .. [6]=g, [7]=dp
//   SA     : digit select, active-low, one-cold
// slave  = display driver side (consumes switches, drives display)
// master = board/pin side (drives switches, observes display)
interface led_7seg_if;
  logic       I1;
  logic       I2;
  logic [7:0] LED;
  logic [3:0] SA;

  modport slave  (input  I1, I2, output LED, SA);
  modport master (output I1, I2, input  LED, SA);
endinterface

// File: rtl/led_7seg.sv
// led_7seg: 4-digit multiplexed common-anode 7-segment driver for two switches.
//   digit0 = {I1,I2} as 0..3, digit1 = I1, digit2 = I2, digit3 = blank.
// Ports:
//   CLK : system clock, rising edge
//   RST : asynchronous active-high reset
//   io  : led_7seg_if.slave (I1, I2 in; LED[7:0], SA[3:0] out, both active-low)
// Parameters:
//   SCAN_DIV : clocks each digit stays selected (>=1)
// Build option:
//   LED7SEG_DP_EN : when defined, dp (LED[7]) is lit on digit0 while s1=s2=1;
//                   otherwise LED[7] stays 1.
module led_7seg #(
  parameter int SCAN_DIV = 1000
) (
  input  logic        CLK,
  input  logic        RST,
  led_7seg_if.slave   io
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} dig_t;

  // Segment patterns, active-low, dp off. Codes 4..7 mean blank.
  function automatic logic [7:0] glyph(input logic [2:0] code);
    case (code)
      3'd0:    glyph = 8'hC0;
      3'd1:    glyph = 8'hF9;
      3'd2:    glyph = 8'hA4;
      3'd3:    glyph = 8'hB0;
      default: glyph = 8'hFF;
    endcase
  endfunction

  logic          s1_meta, s1, s2_meta, s2;
  logic [CW-1:0] cnt;
  logic          wrap;
  dig_t          dig_q, dig_d;
  logic [2:0]    code;
  logic [7:0]    led_d, led_q;
  logic [3:0]    sa_d, sa_q;

  // Two-flop synchronizers; only s1/s2 feed the decoder.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_meta <= 1'b0;
      s1      <= 1'b0;
      s2_meta <= 1'b0;
      s2      <= 1'b0;
    end else begin
      s1_meta <= io.I1;
      s1      <= s1_meta;
      s2_meta <= io.I2;
      s2      <= s2_meta;
    end
  end

  // Prescaler: counts 0..SCAN_DIV-1; wrap advances the scan.
  assign wrap = (cnt == CW'(SCAN_DIV - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)       cnt <= '0;
    else if (wrap) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

  // Scan sequencer state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) dig_q <= DIG0;
    else     dig_q <= dig_d;
  end

  // Next digit and the outputs that the output register will capture.
  always_comb begin
    dig_d = dig_q;
    code  = 3'd4;
    sa_d  = 4'b1111;
    if (wrap) begin
      case (dig_q)
        DIG0:    dig_d = DIG1;
        DIG1:    dig_d = DIG2;
        DIG2:    dig_d = DIG3;
        default: dig_d = DIG0;
      endcase
    end
    case (dig_q)
      DIG0: begin code = {1'b0, s1, s2};   sa_d = 4'b1110; end
      DIG1: begin code = {2'b00, s1};      sa_d = 4'b1101; end
      DIG2: begin code = {2'b00, s2};      sa_d = 4'b1011; end
      // Digit3 still takes its slot so every digit gets equal duty.
      default: begin code = 3'd4;          sa_d = 4'b0111; end
    endcase
    led_d = glyph(code);
`ifdef LED7SEG_DP_EN
    if (dig_q == DIG0 && s1 && s2) led_d[7] = 1'b0;
`endif
  end

  // Registered outputs keep SA glitch-free; SA only changes when dig_q does.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      led_q <= 8'hFF;
      sa_q  <= 4'b1111;
    end else begin
      led_q <= led_d;
      sa_q  <= sa_d;
    end
  end

  assign io.LED = led_q;
  assign io.SA  = sa_q;

endmodule

// File: tb/tb_led_7seg.sv
module tb_led_7seg;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic i1 = 1'b0, i2 = 1'b0;
  always #5 CLK = ~CLK;

  led_7seg_if ifa ();
  led_7seg_if ifb ();
  assign ifa.I1 = i1;
  assign ifa.I2 = i2;
  assign ifb.I1 = i1;
  assign ifb.I2 = i2;

  led_7seg #(.SCAN_DIV(4)) dut_a (.CLK(CLK), .RST(RST), .io(ifa));
  led_7seg #(.SCAN_DIV(1)) dut_b (.CLK(CLK), .RST(RST), .io(ifb));

  int nchk = 0, nfail = 0;
  int n = 0;                 // clock edges since reset release
  bit h1 [0:8191];
  bit h2 [0:8191];

  typedef struct {
    bit         i1, i2;
    logic [7:0] exp [4];
  } vec_t;
  vec_t vecs [4];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s n=%0d got=%h expected=%h", nm, n, act, exp);
    end
  endtask

  // Reference: digit on screen after edge k is selected by (k-1)/div; synchronized
  // value seen at edge k is the pin level sampled two edges earlier (0 before that).
  function automatic int ref_idx(input int div, input int k);
    return ((k - 1) / div) % 4;
  endfunction

  function automatic logic [7:0] ref_led(input int div, input int k);
    logic [7:0] gl [4];
    int idx, v;
    bit a, b;
    logic [7:0] r;
    gl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
    idx = ref_idx(div, k);
    a = (k >= 3) ? h1[k-2] : 1'b0;
    b = (k >= 3) ? h2[k-2] : 1'b0;
    v = (idx == 0) ? 2 * a + b : (idx == 1) ? a : (idx == 2) ? b : -1;
    r = (v < 0) ? 8'hFF : gl[v];
`ifdef LED7SEG_DP_EN
    if (idx == 0 && a && b) r[7] = 1'b0;
`endif
    return r;
  endfunction

  function automatic logic [3:0] ref_sa(input int div, input int k);
    logic [3:0] t;
    t = 4'b0001 << ref_idx(div, k);
    return ~t;
  endfunction

  task automatic tick();
    @(posedge CLK);
    n++;
    h1[n] = i1;
    h2[n] = i2;
    @(negedge CLK);
    chk("led_a", ifa.LED, ref_led(4, n));
    chk("sa_a",  ifa.SA,  ref_sa(4, n));
    chk("led_b", ifb.LED, ref_led(1, n));
    chk("sa_b",  ifb.SA,  ref_sa(1, n));
    chk("onecold_a", 8'($countones(~ifa.SA)), 8'd1);
    chk("onecold_b", 8'($countones(~ifb.SA)), 8'd1);
  endtask

  // Assert reset mid-cycle and check outputs react before the next edge.
  task automatic do_reset();
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("rst_led_a", ifa.LED, 8'hFF);
    chk("rst_sa_a",  ifa.SA,  8'h0F);
    chk("rst_led_b", ifb.LED, 8'hFF);
    chk("rst_sa_b",  ifb.SA,  8'h0F);
    @(negedge CLK);
    RST = 1'b0;
    n = 0;
  endtask

  function automatic int sa_digit(input logic [3:0] sa);
    case (sa)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      default: return 3;
    endcase
  endfunction

  initial begin
    logic [3:0] scan_seq [5];
    scan_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    vecs[0] = '{1'b1, 1'b1, '{8'hB0, 8'hF9, 8'hF9, 8'hFF}};
`ifdef LED7SEG_DP_EN
    vecs[0].exp[0] = 8'h30;
`endif
    vecs[1] = '{1'b0, 1'b1, '{8'hF9, 8'hC0, 8'hF9, 8'hFF}};
    vecs[2] = '{1'b1, 1'b0, '{8'hA4, 8'hF9, 8'hC0, 8'hFF}};
    vecs[3] = '{1'b0, 1'b0, '{8'hC0, 8'hC0, 8'hC0, 8'hFF}};

    // Reset with switches high, then the first post-release clock.
    i1 = 1'b1; i2 = 1'b1;
    repeat (2) @(negedge CLK);
    do_reset();
    tick();
    chk("first_sa",  ifa.SA,  8'h0E);
    chk("first_led", ifa.LED, 8'hC0);

    // Table vectors on the SCAN_DIV=4 instance.
    foreach (vecs[v]) begin
      i1 = vecs[v].i1; i2 = vecs[v].i2;
      do_reset();
      for (int c = 0; c < 24; c++) begin
        tick();
        if (n >= 3) chk($sformatf("vec%0d_dig%0d", v, sa_digit(ifa.SA)),
                        ifa.LED, vecs[v].exp[sa_digit(ifa.SA)]);
      end
    end

    // SCAN_DIV=1: SA walks one digit per clock.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("scan%0d", c), ifb.SA, {4'b0000, scan_seq[c]});
    end

    // Reset mid-scan while digit2 is selected, then restart from digit0.
    do_reset();
    repeat (3) tick();
    chk("midscan_sa", ifb.SA, 8'h0B);
    do_reset();
    tick();
    chk("restart_sa_b", ifb.SA,  8'h0E);
    chk("restart_led_b", ifb.LED, 8'hC0);

    // Randomized switch activity, including mid-slot changes.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(7) == 0) i1 = 1'($urandom);
      if ($urandom_range(7) == 0) i2 = 1'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout n=%0d got=running expected=finished", n);
    $fatal(1, "timeout");
  end

endmodule
